// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the operand-forwarding / load-use hazard unit.
// Optional FWD_PERF_CNT_EN adds the two performance counter outputs.
interface fwd_hazard_unit_if #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 3
) ();
    logic                         advance;
    logic                         flush;
    logic                         id_valid;
    logic                         id_rs_used;
    logic                         id_rt_used;
    logic [ADDR_W-1:0]            id_rs_addr;
    logic [ADDR_W-1:0]            id_rt_addr;
    logic                         id_wen;
    logic [ADDR_W-1:0]            id_dest;
    logic                         id_is_load;
    logic [DATA_W-1:0]            rf_rs_data;
    logic [DATA_W-1:0]            rf_rt_data;
    logic [PIPE_DEPTH*DATA_W-1:0] slot_data;

    logic                         stall;
    logic [DATA_W-1:0]            opa_data;
    logic [DATA_W-1:0]            opb_data;
    logic                         fwd_a_hit;
    logic                         fwd_b_hit;
    logic [2:0]                   fwd_a_slot;
    logic [2:0]                   fwd_b_slot;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]                  stall_cycles;
    logic [31:0]                  fwd_events;
`endif

    // The pipeline drives ID/slot information; the hazard unit answers
    // combinationally in the same cycle (no handshake, advance gates updates).
    modport master (
        output advance, flush, id_valid, id_rs_used, id_rt_used, id_rs_addr,
               id_rt_addr, id_wen, id_dest, id_is_load, rf_rs_data, rf_rt_data,
               slot_data,
        input  stall, opa_data, opb_data, fwd_a_hit, fwd_b_hit, fwd_a_slot,
               fwd_b_slot
`ifdef FWD_PERF_CNT_EN
        , input stall_cycles, fwd_events
`endif
    );

    modport slave (
        input  advance, flush, id_valid, id_rs_used, id_rt_used, id_rs_addr,
               id_rt_addr, id_wen, id_dest, id_is_load, rf_rs_data, rf_rt_data,
               slot_data,
        output stall, opa_data, opb_data, fwd_a_hit, fwd_b_hit, fwd_a_slot,
               fwd_b_slot
`ifdef FWD_PERF_CNT_EN
        , output stall_cycles, fwd_events
`endif
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Scoreboard-based operand forwarding and load-use stall unit at the ID/EXE boundary.
// Define FWD_PERF_CNT_EN to add saturating stall_cycles / fwd_events counters.
module fwd_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_SLOT  = 1
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_unit_if.slave  bus
);
    logic [PIPE_DEPTH-1:0] r_wen;
    logic [PIPE_DEPTH-1:0] r_load;
    logic [ADDR_W-1:0]     r_dest [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0] w_slot_rdy;
    logic                  w_a_match, w_a_rdy, w_b_match, w_b_rdy;
    logic [2:0]            w_a_idx, w_b_idx;
    logic [DATA_W-1:0]     w_a_slot_data, w_b_slot_data;
    logic                  w_a_fwd, w_b_fwd, w_a_block, w_b_block;
    logic                  w_stall;

    // A load only has its result from LOAD_SLOT onwards; everything else is ready at once.
    always_comb begin
        w_slot_rdy = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            w_slot_rdy[k] = !r_load[k] || (k >= LOAD_SLOT);
        end
    end

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        w_a_match     = 1'b0;
        w_a_rdy       = 1'b0;
        w_a_idx       = 3'd0;
        w_a_slot_data = '0;
        w_b_match     = 1'b0;
        w_b_rdy       = 1'b0;
        w_b_idx       = 3'd0;
        w_b_slot_data = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (bus.id_rs_used && (bus.id_rs_addr != '0) && r_wen[k] &&
                (r_dest[k] == bus.id_rs_addr)) begin
                w_a_match     = 1'b1;
                w_a_rdy       = w_slot_rdy[k];
                w_a_idx       = 3'(k);
                w_a_slot_data = bus.slot_data[k*DATA_W +: DATA_W];
            end
            if (bus.id_rt_used && (bus.id_rt_addr != '0) && r_wen[k] &&
                (r_dest[k] == bus.id_rt_addr)) begin
                w_b_match     = 1'b1;
                w_b_rdy       = w_slot_rdy[k];
                w_b_idx       = 3'(k);
                w_b_slot_data = bus.slot_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_a_fwd   = w_a_match & w_a_rdy;
    assign w_b_fwd   = w_b_match & w_b_rdy;
    assign w_a_block = w_a_match & ~w_a_rdy;
    assign w_b_block = w_b_match & ~w_b_rdy;
    assign w_stall   = bus.id_valid & ~bus.flush & (w_a_block | w_b_block);

    assign bus.stall      = w_stall;
    assign bus.fwd_a_hit  = w_a_fwd;
    assign bus.fwd_b_hit  = w_b_fwd;
    assign bus.fwd_a_slot = w_a_fwd ? w_a_idx : 3'd0;
    assign bus.fwd_b_slot = w_b_fwd ? w_b_idx : 3'd0;
    assign bus.opa_data   = w_a_fwd ? w_a_slot_data : bus.rf_rs_data;
    assign bus.opb_data   = w_b_fwd ? w_b_slot_data : bus.rf_rt_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen  <= '0;
            r_load <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_dest[k] <= '0;
            end
        end else if (bus.advance) begin
            for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
                r_wen[k]  <= r_wen[k-1];
                r_dest[k] <= r_dest[k-1];
                r_load[k] <= r_load[k-1];
            end
            if (w_stall || bus.flush) begin
                r_wen[0]  <= 1'b0;
                r_dest[0] <= '0;
                r_load[0] <= 1'b0;
            end else begin
                r_wen[0]  <= bus.id_wen & bus.id_valid;
                r_dest[0] <= bus.id_dest;
                r_load[0] <= bus.id_is_load & bus.id_valid;
            end
            // A taken branch also kills the instruction that was in EXE.
            if (bus.flush) begin
                r_wen[1]  <= 1'b0;
                r_dest[1] <= '0;
                r_load[1] <= 1'b0;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fwd_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_fwd_events   <= '0;
        end else begin
            if (w_stall && bus.advance && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (bus.advance && !w_stall && (w_a_fwd || w_b_fwd) &&
                (r_fwd_events != 32'hFFFF_FFFF)) begin
                r_fwd_events <= r_fwd_events + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.fwd_events   = r_fwd_events;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected outputs queued per step, checked before the next edge.
module tb_fwd_hazard_unit;
  localparam int EW = 73;
  localparam logic [31:0] RS = 32'h1111_0000;
  localparam logic [31:0] RT = 32'h2222_0000;

  logic clk;
  logic rst;
  int total;
  int bad;
  logic [EW-1:0] exp_q[$];

  fwd_hazard_unit_if #(.ADDR_W(5), .DATA_W(32), .PIPE_DEPTH(3)) bus ();

  fwd_hazard_unit #(.ADDR_W(5), .DATA_W(32), .PIPE_DEPTH(3), .LOAD_SLOT(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic adv, input logic fl, input logic valid,
                       input logic rsu, input logic [4:0] rs,
                       input logic rtu, input logic [4:0] rt,
                       input logic wen, input logic [4:0] dest, input logic ld);
    bus.advance    = adv;
    bus.flush      = fl;
    bus.id_valid   = valid;
    bus.id_rs_used = rsu;
    bus.id_rs_addr = rs;
    bus.id_rt_used = rtu;
    bus.id_rt_addr = rt;
    bus.id_wen     = wen;
    bus.id_dest    = dest;
    bus.id_is_load = ld;
  endtask

  task automatic set_sd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    bus.slot_data = {d2, d1, d0};
  endtask

  task automatic push_exp(input logic st, input logic ah, input logic [2:0] as,
                          input logic [31:0] oa, input logic bh, input logic [2:0] bs,
                          input logic [31:0] ob);
    exp_q.push_back({st, ah, as, oa, bh, bs, ob});
  endtask

  // scoreboard: pop one expectation and compare against the settled outputs
  task automatic check(input string tag);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    #2;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no expected entry queued", tag);
      return;
    end
    e = exp_q.pop_front();
    o = {bus.stall, bus.fwd_a_hit, bus.fwd_a_slot, bus.opa_data,
         bus.fwd_b_hit, bus.fwd_b_slot, bus.opb_data};
    total++;
    assert (o[72] === e[72]) else begin
      bad++;
      $error("FAIL %s.stall: got %b want %b", tag, o[72], e[72]);
    end
    total++;
    assert (o[71:36] === e[71:36]) else begin
      bad++;
      $error("FAIL %s.opa{hit,slot,data}: got %b/%0d/%h want %b/%0d/%h", tag,
             o[71], o[70:68], o[67:36], e[71], e[70:68], e[67:36]);
    end
    total++;
    assert (o[35:0] === e[35:0]) else begin
      bad++;
      $error("FAIL %s.opb{hit,slot,data}: got %b/%0d/%h want %b/%0d/%h", tag,
             o[35], o[34:32], o[31:0], e[35], e[34:32], e[31:0]);
    end
  endtask

`ifdef FWD_PERF_CNT_EN
  task automatic check_cnt(input string tag, input logic [31:0] sc, input logic [31:0] fe);
    total++;
    assert (bus.stall_cycles === sc) else begin
      bad++;
      $error("FAIL %s.stall_cycles: got %0d want %0d", tag, bus.stall_cycles, sc);
    end
    total++;
    assert (bus.fwd_events === fe) else begin
      bad++;
      $error("FAIL %s.fwd_events: got %0d want %0d", tag, bus.fwd_events, fe);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.rf_rs_data = RS;
    bus.rf_rt_data = RT;
    set_sd(32'hC0, 32'hC1, 32'hC2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // reset state: empty scoreboard, operands from the register file
    @(negedge clk); drive(1, 0, 1, 1, 3, 1, 5, 0, 0, 0);
    push_exp(0, 0, 0, RS, 0, 0, RT); check("reset");

    @(negedge clk); rst = 1'b0; drive(1, 0, 1, 1, 7, 0, 0, 1, 3, 0);
    push_exp(0, 0, 0, RS, 0, 0, RT); check("alu_issue");

    // ALU back-to-back: r3 in EXE forwarded from slot 0
    @(negedge clk); set_sd(32'h11, 32'hC1, 32'hC2); drive(1, 0, 1, 1, 3, 1, 9, 1, 4, 0);
    push_exp(0, 1, 0, 32'h11, 0, 0, RT); check("alu_b2b");

    @(negedge clk); set_sd(32'hA0, 32'hA1, 32'hC2); drive(1, 0, 1, 1, 3, 1, 4, 1, 5, 1);
    push_exp(0, 1, 1, 32'hA1, 1, 0, 32'hA0); check("two_slots");

    // load-use: r5 load in slot 0 blocks rt=5 for one cycle
    @(negedge clk); set_sd(32'hC0, 32'hC1, 32'hB3); drive(1, 0, 1, 1, 3, 1, 5, 1, 6, 0);
    push_exp(1, 1, 2, 32'hB3, 0, 0, RT); check("load_use_stall");

    @(negedge clk); set_sd(32'hC0, 32'hDEADBEEF, 32'hC2);
    push_exp(0, 0, 0, RS, 1, 1, 32'hDEADBEEF); check("load_use_fwd");

    @(negedge clk); set_sd(32'hC0, 32'hC1, 32'h55AA); drive(1, 0, 1, 1, 5, 0, 0, 1, 4, 0);
    push_exp(0, 1, 2, 32'h55AA, 0, 0, RT); check("load_in_last_slot");

    @(negedge clk); set_sd(32'hC0, 32'h66, 32'hC2); drive(1, 0, 1, 1, 6, 0, 0, 1, 8, 0);
    push_exp(0, 1, 1, 32'h66, 0, 0, RT); check("mem_slot");

    @(negedge clk); set_sd(32'h70, 32'h71, 32'h72); drive(1, 0, 1, 1, 4, 1, 8, 1, 4, 0);
    push_exp(0, 1, 1, 32'h71, 1, 0, 32'h70); check("both_ops");

    // priority: r4 in slot 0 and slot 2, youngest wins
    @(negedge clk); set_sd(32'hA, 32'hC1, 32'hB); drive(1, 0, 1, 1, 4, 0, 0, 1, 9, 0);
    push_exp(0, 1, 0, 32'hA, 0, 0, RT); check("priority");

    @(negedge clk); set_sd(32'h90, 32'hC1, 32'hC2); drive(1, 0, 1, 1, 9, 0, 0, 1, 4, 1);
    push_exp(0, 1, 0, 32'h90, 0, 0, RT); check("issue_load_r4");

    // unready load r4 in slot 0 masks ready r4 in slot 2; freeze holds it 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_sd(32'hC0, 32'h91, 32'hB4); drive(0, 0, 1, 1, 9, 1, 4, 1, 0, 0);
      push_exp(1, 1, 1, 32'h91, 0, 0, RT); check("freeze_stall");
    end

    // flush: stall dropped, slot 0 and 1 become bubbles
    @(negedge clk); drive(1, 1, 1, 1, 9, 1, 4, 1, 0, 0);
    push_exp(0, 1, 1, 32'h91, 0, 0, RT); check("flush");

    @(negedge clk); set_sd(32'hC0, 32'hC1, 32'h92); drive(1, 0, 1, 1, 9, 1, 4, 1, 0, 0);
    push_exp(0, 1, 2, 32'h92, 0, 0, RT); check("after_flush");

    // zero register never matches even with a writer of r0 in slot 0
    @(negedge clk); set_sd(32'h77, 32'hC1, 32'hC2);
    bus.rf_rs_data = 32'h0; bus.rf_rt_data = 32'h55;
    drive(1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    push_exp(0, 0, 0, 32'h0, 0, 0, 32'h55); check("zero_reg");

    @(negedge clk); bus.rf_rs_data = RS; bus.rf_rt_data = RT;
    set_sd(32'hC0, 32'hC1, 32'hC2); drive(1, 0, 1, 0, 0, 0, 0, 1, 7, 1);
    push_exp(0, 0, 0, RS, 0, 0, RT); check("issue_load_r7");

    // stall held by freeze, then reset ends it
    @(negedge clk); drive(0, 0, 1, 0, 0, 1, 7, 0, 0, 0);
    push_exp(1, 0, 0, RS, 0, 0, RT); check("pre_rst_stall1");
    @(negedge clk);
    push_exp(1, 0, 0, RS, 0, 0, RT); check("pre_rst_stall2");
`ifdef FWD_PERF_CNT_EN
    check_cnt("cnt_before_rst", 32'd1, 32'd10);
`endif
    @(negedge clk); rst = 1'b1;
    push_exp(1, 0, 0, RS, 0, 0, RT); check("rst_asserted");
    @(negedge clk); rst = 1'b0;
    push_exp(0, 0, 0, RS, 0, 0, RT); check("rst_cleared");
`ifdef FWD_PERF_CNT_EN
    check_cnt("cnt_after_rst", 32'd0, 32'd0);
`endif

    // id_valid=0 never stalls, yet its unready operand is not forwarded
    @(negedge clk); drive(1, 0, 1, 0, 0, 0, 0, 1, 7, 1);
    push_exp(0, 0, 0, RS, 0, 0, RT); check("reissue_load");
    @(negedge clk); drive(1, 0, 0, 0, 0, 1, 7, 1, 3, 0);
    push_exp(0, 0, 0, RS, 0, 0, RT); check("invalid_no_stall");
    @(negedge clk); set_sd(32'hC0, 32'hE7, 32'hC2); drive(1, 0, 1, 0, 0, 1, 7, 0, 0, 0);
    push_exp(0, 0, 0, RS, 1, 1, 32'hE7); check("load_slot1_fwd");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected entries unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the 5-stage MIPS pipelined CPU.
- Replaces the fixed EXE/MEM/WB forwarding muxes and the single-cycle load-use stall with a scoreboard of in-flight writers of configurable depth and load latency.
- Sits at the ID/EXE boundary. It supplies fully bypassed operands A/B to the ID/EXE register and drives the ID stall.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- PIPE_DEPTH, 3, number of tracked slots after ID. Slot k holds the instruction that entered EXE k advances ago. With 3 slots: slot 0=EXE, 1=MEM, 2=WB. Legal range 2..8.
- LOAD_SLOT, 1, first slot at which a load result is valid. Must be less than PIPE_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- advance  in  1  pipeline moves this cycle. 0 = global freeze.
- flush  in  1  kill the ID instruction and slot 0 (taken branch).
- id_valid  in  1  ID holds a real instruction.
- id_rs_used, id_rt_used  in  1 each  operand is read.
- id_rs_addr, id_rt_addr  in  ADDR_W each  source register numbers.
- id_wen  in  1  ID instruction writes a register.
- id_dest  in  ADDR_W  destination register.
- id_is_load  in  1  ID instruction is a load.
- rf_rs_data, rf_rt_data  in  DATA_W each  register-file read data.
- slot_data  in  PIPE_DEPTH*DATA_W  result offered by each slot. Slot k occupies bits [k*DATA_W +: DATA_W].
- stall  out  1  hold IF/ID and insert a bubble.
- opa_data, opb_data  out  DATA_W each  bypassed rs/rt values.
- fwd_a_hit, fwd_b_hit  out  1 each  operand taken from a slot.
- fwd_a_slot, fwd_b_slot  out  3 each  slot index used. 0 when no hit.

Behaviour:
- Scoreboard:
  - Each slot is a register holding {wen, dest, is_load}.
  - A slot is "ready" if is_load=0, or if is_load=1 and its index >= LOAD_SLOT.
- Match rules:
  - An operand matches slot k when the operand is used, its address is nonzero, slot.wen=1, and slot.dest equals the operand address.
  - Register 0 never matches.
  - When several slots match, the lowest index (youngest writer) wins.
- Forwarding (combinational, 0-cycle):
  - Hit on a ready slot: operand = slot_data of that slot.
  - No hit: operand = rf data.
- Stall (combinational): stall=1 when id_valid=1, flush=0, and either operand's winning slot is not ready. An older ready match never overrides a younger unready one.
- On a clock edge with advance=1:
  - Slot k+1 takes slot k.
  - The last slot's contents are retired.
  - Slot 0 takes {id_wen & id_valid, id_dest, id_is_load} when stall=0 and flush=0; otherwise it takes a bubble (wen=0).
  - If flush=1, slot 1 also receives a bubble instead of the old slot 0.
- On a clock edge with advance=0: all slots hold. stall and operands are still evaluated from the held state.
- Load-use with default parameters gives exactly one stall cycle. In general the stall lasts LOAD_SLOT cycles.
- Reset:
  - All slots are cleared (wen=0, dest=0, is_load=0).
  - Outputs after reset: stall=0, hits=0, slots=0, opa/opb=rf data.
  - rst has priority over advance and flush. A reset during a stall ends the stall on the next cycle.
- Retired writes are assumed visible through rf data. The last slot covers the same-cycle regfile write.

Optional Feature:
- Macro FWD_PERF_CNT_EN. When defined, the unit adds these outputs:
  - stall_cycles (32 bits): counts cycles with stall=1 and advance=1.
  - fwd_events (32 bits): counts advancing cycles with stall=0 and at least one hit.
- Both counters saturate at 0xFFFF_FFFF and clear on rst.
- Without the macro, neither the ports nor the counter logic exist.

Test Plan:
- ALU back-to-back: slot0 {wen=1, dest=3}; ID rs=3; slot_data[0]=0x11 -> stall=0, opa=0x11, fwd_a_slot=0.
- Load-use (LOAD_SLOT=1): slot0 {load, dest=5}; ID rt=5 -> stall=1 for 1 cycle. Next cycle the load is in slot1 with slot_data[1]=0xDEADBEEF -> opb=0xDEADBEEF, fwd_b_slot=1, stall=0.
- Priority: dest=4 in slot0 (0xA) and in slot2 (0xB); ID rs=4 -> opa=0xA. Unready load r4 in slot0 with ready r4 in slot2 -> stall=1.
- Zero register: slot0 {wen=1, dest=0}; rs=0, rf_rs_data=0x0 -> fwd_a_hit=0, opa=0.
- Freeze and flush: advance=0 for 3 cycles -> slots unchanged. flush=1 with advance=1 -> slot0 and slot1 become bubbles and stall drops to 0.
- Reset mid-stall plus counters (FWD_PERF_CNT_EN): 2 stall cycles, then rst=1 -> stall=0 next cycle, stall_cycles=0, fwd_events=0.
